// File: rtl/gate_arb_pkg.sv
// gate_arb_pkg: opcode and FSM state encodings shared by the gate-op arbiter.
package gate_arb_pkg;
  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_t;
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;
endpackage

// File: rtl/gate_logic_unit.sv
// gate_logic_unit: combinational opcode-selected bitwise AND/OR/XOR/NAND.
module gate_logic_unit
  import gate_arb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  always_comb
    y = op == OP_AND ? a & b :
        op == OP_OR  ? a | b :
        op == OP_XOR ? a ^ b : ~(a & b);
endmodule

// File: rtl/gate_op_arbiter.sv
// gate_op_arbiter: round-robin sharing of one registered logic unit among NUM_REQ requesters.
// Define GATE_ARB_LOCK_EN to add the lock port that lets the last winner keep ownership.
module gate_op_arbiter
  import gate_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = 8,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [2*NUM_REQ-1:0]     op,
  input  logic [WIDTH*NUM_REQ-1:0] a,
  input  logic [WIDTH*NUM_REQ-1:0] b,
`ifdef GATE_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]       lock,
`endif
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     rsp_valid,
  output logic [IDW-1:0]           rsp_id,
  output logic [WIDTH-1:0]         rsp_data
);
  state_t           state;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   win;
  op_t              op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res;

  // Scan downward from the farthest slot so the nearest set request after ptr wins.
  always_comb begin
    win = ptr;
    for (int k = NUM_REQ; k >= 1; k--)
      if (req[IDW'((int'(ptr) + k) % NUM_REQ)]) win = IDW'((int'(ptr) + k) % NUM_REQ);
`ifdef GATE_ARB_LOCK_EN
    if (req[ptr] && lock[ptr]) win = ptr;
`endif
  end

  gate_logic_unit #(.WIDTH(WIDTH)) u_glu (
    .op(op_q),
    .a (a_q),
    .b (b_q),
    .y (res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= IDW'(NUM_REQ - 1);
      op_q      <= OP_AND;
      a_q       <= '0;
      b_q       <= '0;
      gnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      gnt       <= '0;
      rsp_valid <= 1'b0;
      if (state == ST_EXEC) begin
        rsp_data  <= res;
        rsp_id    <= ptr;
        rsp_valid <= 1'b1;
        state     <= ST_RESP;
      end else if (|req) begin
        ptr   <= win;
        op_q  <= op_t'(op[2*win +: 2]);
        a_q   <= a[WIDTH*win +: WIDTH];
        b_q   <= b[WIDTH*win +: WIDTH];
        gnt   <= NUM_REQ'(1) << win;
        state <= ST_EXEC;
      end else begin
        state <= ST_IDLE;
      end
    end
  end
endmodule
